// File: rtl/udp_length_prepend_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_length_prepend_buffer_if
// Description : AXI4-Stream style bus (tdata/tvalid/tready/tlast/tuser) used
//               for both the input and output sides of the length-prepend
//               buffer. tuser marks the first word of a packet.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_length_prepend_buffer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/udp_length_prepend_buffer.sv
`default_nettype none
// ============================================================================
// Module      : udp_length_prepend_buffer
// Description : Store-and-forward packet buffer. Each complete input packet
//               is re-emitted prefixed by one word carrying its length in
//               bytes (tuser=1 on that word). Packets longer than MAX_WORDS
//               are truncated by default; defining UDP_LEN_PREPEND_DROP_EN
//               drops them entirely instead.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_length_prepend_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024,
  parameter int LEN_DEPTH  = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                   aclk,
  input  wire logic                   aresetn,
  udp_length_prepend_buffer_if.slave  s_axis,
  udp_length_prepend_buffer_if.master m_axis,
  output logic [$clog2(LEN_DEPTH):0]  pkt_avail,
  output logic [CNT_WIDTH-1:0]        oversize_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DAW   = $clog2(DATA_DEPTH);
  localparam int LAW   = $clog2(LEN_DEPTH);
  localparam int WCW   = $clog2(MAX_WORDS + 1);
  localparam logic [DAW:0]   DATA_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [LAW+1:0] LEN_FULL  = (LAW+2)'(LEN_DEPTH);
  localparam logic [WCW-1:0] MAX_CNT   = WCW'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LEN = 2'd1, S_DATA = 2'd2} state_t;

  function automatic logic [DATA_WIDTH-1:0] words_to_bytes(input logic [WCW-1:0] words);
    return DATA_WIDTH'(32'(words) * BYTES);
  endfunction

  logic                  rst_n_q;
  logic [DATA_WIDTH:0]   data_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] len_mem  [LEN_DEPTH];
  logic [DAW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q;
  logic [LAW-1:0]        len_wr_q, len_rd_q;
  logic [LAW:0]          pkt_avail_q;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q;
  logic [WCW-1:0]        cnt_q, cnt_d, w_cnt_next;
  logic                  discard_q, discard_d;
  logic                  commit_q, commit_d;
  logic [DATA_WIDTH-1:0] commit_len_q, commit_len_d;
  logic                  w_accept, w_data_full, w_len_full, w_skip;
  logic                  w_wr_en, w_wr_last, w_ovf_inc, w_pop, w_rd;
  logic [DAW-1:0]        w_wr_addr;
  logic [LAW+1:0]        w_len_used;
  logic [DATA_WIDTH:0]   w_head;
  state_t                state_q, state_d;
`ifdef UDP_LEN_PREPEND_DROP_EN
  logic [DAW:0]          commit_ptr_q, commit_ptr_d, w_base;
  logic                  in_pkt_q, in_pkt_d, w_restart, w_oversize;
`endif

  assign pkt_avail      = pkt_avail_q;
  assign oversize_count = ovf_cnt_q;

  // A pending (registered) length commit already claims a length-FIFO slot.
  assign w_len_used  = (LAW+2)'(pkt_avail_q) + (LAW+2)'(commit_q);
  assign w_len_full  = (w_len_used >= LEN_FULL);
  assign w_data_full = ((wr_ptr_q - rd_ptr_q) == DATA_FULL);
`ifdef UDP_LEN_PREPEND_DROP_EN
  // Words that will be thrown away never need FIFO space; without this an
  // oversize packet filling the whole FIFO could never reach its tlast.
  assign w_skip = discard_q | (in_pkt_q & (cnt_q == MAX_CNT));
`else
  assign w_skip = 1'b0;
`endif
  assign s_axis.tready = rst_n_q & (~w_data_full | w_skip) & ~w_len_full;
  assign w_accept      = s_axis.tvalid & s_axis.tready;
  assign w_cnt_next    = s_axis.tuser ? WCW'(1) : cnt_q + WCW'(1);

  // Release the internal reset one clock after aresetn rises; assertion is immediate.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_n_q <= 1'b0;
    else          rst_n_q <= 1'b1;
  end

  // Input path: word counting, FIFO write decision and oversize handling.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    commit_d     = 1'b0;
    commit_len_d = commit_len_q;
    w_wr_en      = 1'b0;
    w_wr_addr    = wr_ptr_q[DAW-1:0];
    w_wr_last    = s_axis.tlast;
    w_ovf_inc    = 1'b0;
`ifdef UDP_LEN_PREPEND_DROP_EN
    commit_ptr_d = commit_ptr_q;
    in_pkt_d     = in_pkt_q;
    w_restart    = s_axis.tuser & in_pkt_q;
    w_oversize   = ~s_axis.tuser & in_pkt_q & (cnt_q == MAX_CNT);
    // A tuser arriving mid-packet abandons the partial packet: rewrite from the last commit.
    w_base       = w_restart ? commit_ptr_q : wr_ptr_q;
    if (w_accept) begin
      if (discard_q && !s_axis.tuser) begin
        if (s_axis.tlast) discard_d = 1'b0;
      end else if (w_oversize) begin
        wr_ptr_d  = commit_ptr_q;
        in_pkt_d  = 1'b0;
        discard_d = ~s_axis.tlast;
        w_ovf_inc = 1'b1;
      end else begin
        discard_d = 1'b0;
        w_ovf_inc = w_restart;
        w_wr_en   = 1'b1;
        w_wr_addr = w_base[DAW-1:0];
        wr_ptr_d  = w_base + 1'b1;
        cnt_d     = w_cnt_next;
        if (s_axis.tlast) begin
          commit_ptr_d = w_base + 1'b1;
          commit_d     = 1'b1;
          commit_len_d = words_to_bytes(w_cnt_next);
          in_pkt_d     = 1'b0;
        end else begin
          in_pkt_d = 1'b1;
        end
      end
    end
`else
    // A tuser mid-packet only restarts the count; the stale words remain and
    // are emitted ahead of the next packet's data (misuse, not recovered).
    if (w_accept) begin
      if (discard_q && !s_axis.tuser) begin
        if (s_axis.tlast) discard_d = 1'b0;
      end else begin
        discard_d = 1'b0;
        cnt_d     = w_cnt_next;
        w_wr_en   = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        if (s_axis.tlast || (w_cnt_next == MAX_CNT)) begin
          w_wr_last    = 1'b1;
          commit_d     = 1'b1;
          commit_len_d = words_to_bytes(w_cnt_next);
          if (!s_axis.tlast) begin
            discard_d = 1'b1;
            w_ovf_inc = 1'b1;
          end
        end
      end
    end
`endif
  end

  // Input-side state registers.
  always_ff @(posedge aclk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      commit_q     <= 1'b0;
      commit_len_q <= '0;
      ovf_cnt_q    <= '0;
`ifdef UDP_LEN_PREPEND_DROP_EN
      commit_ptr_q <= '0;
      in_pkt_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      commit_q     <= commit_d;
      commit_len_q <= commit_len_d;
      if (w_ovf_inc && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
`ifdef UDP_LEN_PREPEND_DROP_EN
      commit_ptr_q <= commit_ptr_d;
      in_pkt_q     <= in_pkt_d;
`endif
    end
  end

  // Storage arrays carry no reset; pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (w_wr_en) data_mem[w_wr_addr] <= {w_wr_last, s_axis.tdata};
  end

  // Length words land one cycle after the packet's tlast was accepted.
  always_ff @(posedge aclk) begin
    if (commit_q) len_mem[len_wr_q] <= commit_len_q;
  end

  assign w_head = data_mem[rd_ptr_q[DAW-1:0]];

  // Output FSM next-state and bus drive; outputs are functions of stored state only.
  always_comb begin
    state_d       = state_q;
    w_pop         = 1'b0;
    w_rd          = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tuser  = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (pkt_avail_q != '0) state_d = S_LEN;
      end
      S_LEN: begin
        m_axis.tvalid = 1'b1;
        m_axis.tuser  = 1'b1;
        m_axis.tdata  = len_mem[len_rd_q];
        if (m_axis.tready) begin
          w_pop   = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = w_head[DATA_WIDTH];
        m_axis.tdata  = w_head[DATA_WIDTH-1:0];
        if (m_axis.tready) begin
          w_rd = 1'b1;
          if (w_head[DATA_WIDTH]) state_d = (pkt_avail_q != '0) ? S_LEN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output-side state registers and packet availability count.
  always_ff @(posedge aclk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      len_wr_q    <= '0;
      len_rd_q    <= '0;
      pkt_avail_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_rd)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (commit_q) len_wr_q <= len_wr_q + 1'b1;
      if (w_pop)    len_rd_q <= len_rd_q + 1'b1;
      case ({commit_q, w_pop})
        2'b10:   pkt_avail_q <= pkt_avail_q + 1'b1;
        2'b01:   pkt_avail_q <= pkt_avail_q - 1'b1;
        default: pkt_avail_q <= pkt_avail_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_udp_length_prepend_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_length_prepend_buffer
// Description : Directed self-checking bench for udp_length_prepend_buffer
//               (16-bit stream, MAX_WORDS=8). Expected oversize behaviour
//               follows UDP_LEN_PREPEND_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_length_prepend_buffer;
  localparam int DW   = 16;
  localparam int MAXW = 8;

  logic        clk     = 1'b0;
  logic        aresetn = 1'b0;
  logic [5:0]  pkt_avail;
  logic [15:0] oversize_count;
  int          n_run  = 0;
  int          n_fail = 0;
  int          cyc    = 0;

  udp_length_prepend_buffer_if #(.DATA_WIDTH(DW)) s_if ();
  udp_length_prepend_buffer_if #(.DATA_WIDTH(DW)) m_if ();

  udp_length_prepend_buffer #(
    .DATA_WIDTH(DW), .DATA_DEPTH(1024), .LEN_DEPTH(32), .MAX_WORDS(MAXW), .CNT_WIDTH(16)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
    .pkt_avail(pkt_avail), .oversize_count(oversize_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output beats {tuser, tlast, tdata}, captured mid-cycle ahead of the handshake edge.
  logic [17:0] got_q[$];
  int          got_cyc[$];
  logic [17:0] exp_q[$];

  always @(negedge clk) begin
    #1;
    if (m_if.tvalid && m_if.tready) begin
      got_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
      got_cyc.push_back(cyc);
    end
  end

  function automatic void add_pkt(input int n, input logic [15:0] base, input logic [15:0] len);
    exp_q.push_back({2'b10, len});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), base + 16'(i)});
  endfunction

  function automatic void clear_q();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endfunction

  task automatic send_word(input logic [15:0] d, input logic u, input logic l);
    int t;
    t = 0;
    s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
    while (!s_if.tready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_run++; n_fail++;
      $display("FAIL send_timeout: tready stayed %b, required 1", s_if.tready);
    end
    @(negedge clk);
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) send_word(base + 16'(i), (i == 0), (i == n - 1));
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int t = 0; t < budget && got_q.size() < n; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    n_run++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b, required 0", s_if.tready); end
    n_run++; if ({m_if.tvalid, m_if.tuser, m_if.tlast} !== 3'b000) begin n_fail++; $display("FAIL reset_m_flags: got %b, required 000", {m_if.tvalid, m_if.tuser, m_if.tlast}); end
    n_run++; if (m_if.tdata !== 16'h0000) begin n_fail++; $display("FAIL reset_m_tdata: got %h, required 0000", m_if.tdata); end
    n_run++; if (pkt_avail !== 6'd0) begin n_fail++; $display("FAIL reset_pkt_avail: got %0d, required 0", pkt_avail); end
    n_run++; if (oversize_count !== 16'd0) begin n_fail++; $display("FAIL reset_oversize: got %0d, required 0", oversize_count); end
    aresetn = 1'b1;
    @(negedge clk);
    n_run++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready: got %b, required 1", s_if.tready); end
  endtask

  task automatic test_single_packet();
    int k0;
    clear_q();
    m_if.tready = 1'b1;
    add_pkt(4, 16'h1000, 16'h0008);
    send_pkt(4, 16'h1000);
    k0 = cyc;
    @(negedge clk);
    n_run++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b, required 0", m_if.tvalid); end
    n_run++; if (pkt_avail !== 6'd1) begin n_fail++; $display("FAIL single_pkt_avail_1: got %0d, required 1", pkt_avail); end
    @(negedge clk);
    n_run++; if ({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata} !== {3'b110, 16'h0008}) begin
      n_fail++; $display("FAIL single_len_word: got v%b u%b l%b %h, required v1 u1 l0 0008", m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata);
    end
    wait_beats(5, 50);
    n_run++; if (got_q.size() != 5) begin n_fail++; $display("FAIL single_count: got %0d beats, required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_run++; if (got_cyc.size() > 0 && got_cyc[0] != k0 + 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 2", got_cyc[0] - k0); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_run++; if (got_cyc[i] != got_cyc[i-1] + 1) begin n_fail++; $display("FAIL single_gap%0d: got gap %0d, required 1", i, got_cyc[i] - got_cyc[i-1]); end
    end
    @(negedge clk);
    n_run++; if (pkt_avail !== 6'd0) begin n_fail++; $display("FAIL single_pkt_avail_0: got %0d, required 0", pkt_avail); end
  endtask

  task automatic test_one_word();
    clear_q();
    m_if.tready = 1'b1;
    exp_q.push_back({2'b10, 16'h0002});
    exp_q.push_back({2'b01, 16'hBEEF});
    send_word(16'hBEEF, 1'b1, 1'b1);
    wait_beats(2, 50);
    repeat (5) @(negedge clk);
    n_run++; if (got_q.size() != 2) begin n_fail++; $display("FAIL one_word_count: got %0d beats, required 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL one_word_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    m_if.tready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send_pkt(6, 16'h2000 + 16'(p * 256));
      add_pkt(6, 16'h2000 + 16'(p * 256), 16'h000C);
    end
    repeat (2) @(negedge clk);
    n_run++; if (pkt_avail !== 6'd3) begin n_fail++; $display("FAIL b2b_pkt_avail: got %0d, required 3", pkt_avail); end
    for (int r = 0; r < 2; r++) begin
      n_run++; if ({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata} !== {3'b110, 16'h000C}) begin
        n_fail++; $display("FAIL b2b_stall_%0d: got v%b u%b l%b %h, required v1 u1 l0 000c", r, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata);
      end
      repeat (5) @(negedge clk);
    end
    m_if.tready = 1'b1;
    wait_beats(21, 100);
    n_run++; if (got_q.size() != 21) begin n_fail++; $display("FAIL b2b_count: got %0d beats, required 21", got_q.size()); end
    for (int i = 0; i < 21 && i < got_q.size(); i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_run++; if (got_cyc[i] != got_cyc[i-1] + 1) begin n_fail++; $display("FAIL b2b_gap%0d: got gap %0d, required 1", i, got_cyc[i] - got_cyc[i-1]); end
    end
  endtask

  task automatic test_len_fifo_full();
    clear_q();
    m_if.tready = 1'b0;
    for (int p = 0; p < 32; p++) begin
      n_run++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL full_early_tready_pkt%0d: got %b, required 1", p, s_if.tready); end
      send_pkt(2, 16'h3000 + 16'(p * 16));
      add_pkt(2, 16'h3000 + 16'(p * 16), 16'h0004);
    end
    n_run++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL full_tready_after_32: got %b, required 0", s_if.tready); end
    repeat (3) @(negedge clk);
    n_run++; if (pkt_avail !== 6'd32) begin n_fail++; $display("FAIL full_pkt_avail: got %0d, required 32", pkt_avail); end
    n_run++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL full_tready_hold: got %b, required 0", s_if.tready); end
    m_if.tready = 1'b1;
    wait_beats(3, 50);
    m_if.tready = 1'b0;
    @(negedge clk);
    n_run++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL full_tready_after_drain: got %b, required 1", s_if.tready); end
    n_run++; if (pkt_avail !== 6'd31) begin n_fail++; $display("FAIL full_pkt_avail_31: got %0d, required 31", pkt_avail); end
    m_if.tready = 1'b1;
    wait_beats(96, 400);
    repeat (5) @(negedge clk);
    n_run++; if (got_q.size() != 96) begin n_fail++; $display("FAIL full_count: got %0d beats, required 96", got_q.size()); end
    for (int i = 0; i < 96 && i < got_q.size(); i += 31) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_run++; if (got_q.size() == 96 && got_q[95] !== {2'b01, 16'h31F1}) begin n_fail++; $display("FAIL full_last_beat: got %h, required 131f1", got_q[95]); end
    n_run++; if (pkt_avail !== 6'd0) begin n_fail++; $display("FAIL full_pkt_avail_end: got %0d, required 0", pkt_avail); end
  endtask

  task automatic test_oversize();
    clear_q();
    m_if.tready = 1'b1;
`ifndef UDP_LEN_PREPEND_DROP_EN
    add_pkt(8, 16'h4000, 16'h0010);
`endif
    add_pkt(2, 16'h5000, 16'h0004);
    send_pkt(10, 16'h4000);
    send_pkt(2, 16'h5000);
    wait_beats(exp_q.size(), 100);
    repeat (10) @(negedge clk);
    n_run++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL oversize_count_beats: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL oversize_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_run++; if (oversize_count !== 16'd1) begin n_fail++; $display("FAIL oversize_counter: got %0d, required 1", oversize_count); end
  endtask

  task automatic test_reset_mid_packet();
    clear_q();
    m_if.tready = 1'b0;
    send_pkt(2, 16'h7000);
    send_pkt(2, 16'h7100);
    send_word(16'h7200, 1'b1, 1'b0);
    send_word(16'h7201, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_run++; if (pkt_avail !== 6'd2) begin n_fail++; $display("FAIL rstmid_pkt_avail_pre: got %0d, required 2", pkt_avail); end
    aresetn = 1'b0;
    #1;
    n_run++; if ({m_if.tvalid, m_if.tuser, m_if.tlast} !== 3'b000) begin n_fail++; $display("FAIL rstmid_m_flags: got %b, required 000", {m_if.tvalid, m_if.tuser, m_if.tlast}); end
    n_run++; if (m_if.tdata !== 16'h0000) begin n_fail++; $display("FAIL rstmid_m_tdata: got %h, required 0000", m_if.tdata); end
    n_run++; if (pkt_avail !== 6'd0) begin n_fail++; $display("FAIL rstmid_pkt_avail: got %0d, required 0", pkt_avail); end
    n_run++; if (oversize_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_oversize: got %0d, required 0", oversize_count); end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    n_run++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tready: got %b, required 1", s_if.tready); end
    m_if.tready = 1'b1;
    add_pkt(3, 16'h8000, 16'h0006);
    send_pkt(3, 16'h8000);
    wait_beats(4, 50);
    repeat (10) @(negedge clk);
    n_run++; if (got_q.size() != 4) begin n_fail++; $display("FAIL rstmid_count: got %0d beats, required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_beat%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_single_packet();
    test_one_word();
    test_back_to_back();
    test_len_fifo_full();
    test_oversize();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
